mouse_packet_decoder: RTL and testbench
=======================================

// Module: mouse_packet_decoder
// PURPOSE
//  Mouse-side producer of the position/button bus that feeds the 65 MHz game-domain registers.
//  - Takes PS/2 mouse bytes from the byte receiver and assembles 3-byte movement packets.
//  - Accumulates signed deltas into clamped absolute xpos/ypos and updates the left button.
//  - Single clock domain, placed between the PS/2 byte receiver and the position register stage.
// PARAMETERS
//  XMAX         1023     max xpos (screen width-1)
//  YMAX         767      max ypos (screen height-1)
//  XPOS_INIT    512      xpos after reset
//  YPOS_INIT    384      ypos after reset
//  TIMEOUT_CYC  130000   max idle cycles between bytes of one packet (~2 ms @ 65 MHz)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-low reset
//  rx_data     in   8   received PS/2 byte
//  rx_valid    in   1   one-cycle strobe, rx_data valid
//  rx_err      in   1   one-cycle strobe, parity/frame error on current byte
//  xpos        out  12  absolute x, 0..XMAX
//  ypos        out  12  absolute y, 0..YMAX (0 = top)
//  mouse_left  out  1   left button state
//  pkt_valid   out  1   one-cycle strobe, new packet applied
//  sync_err    out  1   one-cycle strobe, byte dropped / packet aborted
// BEHAVIOUR
//  Reset (rst==0 at clk edge)
//  - xpos=XPOS_INIT, ypos=YPOS_INIT, mouse_left=0, pkt_valid=0, sync_err=0.
//  - State=B0, idle counter=0.
//  - Reset mid-packet discards all partial bytes.
//  FSM states B0 -> B1 -> B2 -> B0, advancing on rx_valid only.
//  - B0: accept only if rx_data[3]==1, then latch byte0 and go to B1.
//    Else stay in B0 and pulse sync_err.
//  - B1: latch byte1 (dx[7:0]), go to B2.
//  - B2: latch byte2 (dy[7:0]), go to B0, apply packet.
//  byte0 fields
//  - [0] left button
//  - [4] dx sign, [5] dy sign
//  - [6] x overflow, [7] y overflow
//  Deltas are 9-bit two's complement {sign,byte}, range -256..+255.
//  Apply packet: registered, takes effect on the cycle after the B2 rx_valid.
//  - Outputs update and pkt_valid=1 in that same cycle.
//  - mouse_left <= byte0[0] always.
//  - x: if byte0[6]==1, xpos unchanged; else xpos <= clamp(xpos+dx, 0, XMAX).
//  - y: if byte0[7]==1, ypos unchanged; else ypos <= clamp(ypos-dy, 0, YMAX).
//    PS/2 +dy means up on screen.
//  Arithmetic: 14-bit signed intermediate, no wrap-around ever.
//  - Result <0 gives 0; result >MAX gives MAX.
//  Idle timeout
//  - In B1/B2 the idle counter increments each cycle without rx_valid and clears on rx_valid.
//  - Reaching TIMEOUT_CYC forces B0 and pulses sync_err.
//  - rx_valid on the same cycle as timeout counts as a new B0 byte.
//  rx_err with rx_valid: the byte is ignored, state forced to B0, sync_err pulses.
//  - Outputs hold their values.
//  Outputs hold between packets. pkt_valid and sync_err are never high in the same cycle.
// STRUCTURE
//  mouse_pkg holds:
//  - state enum {B0,B1,B2}
//  - byte0 bit indices (BTN_L=0, SYNC=3, XS=4, YS=5, XOV=6, YOV=7)
//  - XMAX/YMAX defaults
//  Sub-module mouse_axis_acc: clamped accumulator, instantiated twice (x, y).
//  - Ports: clk, rst, en, delta[8:0], neg, max[11:0], init[11:0], pos[11:0].
//  Top level contains the FSM, byte latches and idle counter.
// TESTING
//  1. Reset -> xpos=512, ypos=384, mouse_left=0, pkt_valid=0.
//  2. Bytes 09,05,03 -> the cycle after the 3rd rx_valid: xpos=517, ypos=381, mouse_left=1,
//     pkt_valid high for exactly 1 cycle.
//  3. Packet 08,FF,00 x3 from reset -> xpos 767, 1022, 1023 (clamped).
//     Packet 28,00,00 x2 -> ypos 640, then 767.
//  4. Packet 18,00,00 x3 from reset -> xpos 256, 0, 0 (lower clamp).
//  5. Byte 00 (bit3=0), then 08,01,01 -> sync_err on the 1st byte, then xpos=513, ypos=383.
//  6. TIMEOUT_CYC=100: 08, idle 100 cycles, then 09,02,00 -> sync_err on timeout; xpos+2, left=1.
//     Packet C9,7F,7F (overflow bits) -> positions unchanged, left=1, pkt_valid=1.
//     rst low after 2 bytes -> reset values, next 3 bytes decode as a fresh packet.

Source files
------------

// File: rtl/mouse_pkg.sv
// ============================================================================
// Module   : mouse_pkg
// Brief    : Shared types and constants for the PS/2 mouse packet decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mouse_pkg;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } state_t;

    // Bit positions inside the first byte of a movement packet
    localparam int BTN_L = 0;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XOV   = 6;
    localparam int YOV   = 7;

    localparam logic [11:0] XMAX_DEF = 12'd1023;
    localparam logic [11:0] YMAX_DEF = 12'd767;

    typedef struct packed {
        logic yov;
        logic xov;
        logic ys;
        logic xs;
        logic btn_l;
    } b0_flags_t;

endpackage

`default_nettype wire

// File: rtl/mouse_axis_acc.sv
// ============================================================================
// Module   : mouse_axis_acc
// Brief    : Clamped absolute-position accumulator for one mouse axis.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_axis_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [8:0]  delta,
    input  logic        neg,
    input  logic [11:0] max,
    input  logic [11:0] init,
    output logic [11:0] pos
);

    logic signed [13:0] w_delta;
    logic signed [13:0] w_step;
    logic signed [13:0] w_sum;
    logic        [11:0] w_next;

    // 14 bits hold 4095 + 256 and -256 without wrapping
    assign w_delta = {{5{delta[8]}}, delta};
    assign w_step  = neg ? -w_delta : w_delta;
    assign w_sum   = $signed({2'b00, pos}) + w_step;

    always_comb begin
        w_next = w_sum[11:0];
        if (w_sum < 14'sd0) begin
            w_next = 12'd0;
        end else if (w_sum > $signed({2'b00, max})) begin
            w_next = max;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pos <= init;
        end else if (en) begin
            pos <= w_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mouse_packet_decoder.sv
// ============================================================================
// Module   : mouse_packet_decoder
// Brief    : Assembles 3-byte PS/2 mouse packets into clamped xpos/ypos/button.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_packet_decoder
    import mouse_pkg::*;
#(
    parameter logic [11:0] XMAX        = XMAX_DEF,
    parameter logic [11:0] YMAX        = YMAX_DEF,
    parameter logic [11:0] XPOS_INIT   = 12'd512,
    parameter logic [11:0] YPOS_INIT   = 12'd384,
    parameter int          TIMEOUT_CYC = 130000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        mouse_left,
    output logic        pkt_valid,
    output logic        sync_err
);

    localparam int                  c_CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0]  c_TIMEOUT = c_CNT_W'(TIMEOUT_CYC);

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_eff_state;
    b0_flags_t          r_b0;
    logic [7:0]         r_b1;
    logic [c_CNT_W-1:0] r_idle;
    logic               r_pkt_valid;
    logic               r_sync_err;
    logic               r_left;

    logic               w_timeout;
    logic               w_good;
    logic               w_latch0;
    logic               w_latch1;
    logic               w_apply;
    logic               w_sync;

    // A byte arriving on the timeout cycle is treated as a fresh first byte
    assign w_timeout   = (r_state != B0) && (r_idle >= c_TIMEOUT);
    assign w_eff_state = w_timeout ? B0 : r_state;
    assign w_good      = rx_valid && !rx_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= B0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_eff_state;
        if (rx_valid) begin
            if (rx_err) begin
                w_state_nxt = B0;
            end else begin
                case (w_eff_state)
                    B0:      w_state_nxt = rx_data[SYNC] ? B1 : B0;
                    B1:      w_state_nxt = B2;
                    default: w_state_nxt = B0;
                endcase
            end
        end
    end

    always_comb begin
        w_latch0 = w_good && (w_eff_state == B0) && rx_data[SYNC];
        w_latch1 = w_good && (w_eff_state == B1);
        w_apply  = w_good && (w_eff_state == B2);
        w_sync   = w_timeout
                 || (rx_valid && rx_err)
                 || (w_good && (w_eff_state == B0) && !rx_data[SYNC]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_b0        <= '0;
            r_b1        <= 8'd0;
            r_idle      <= '0;
            r_pkt_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            r_left      <= 1'b0;
        end else begin
            if (w_latch0) begin
                r_b0 <= '{yov:   rx_data[YOV],
                          xov:   rx_data[XOV],
                          ys:    rx_data[YS],
                          xs:    rx_data[XS],
                          btn_l: rx_data[BTN_L]};
            end
            if (w_latch1) begin
                r_b1 <= rx_data;
            end
            if (rx_valid || w_timeout || (r_state == B0)) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + c_CNT_W'(1);
            end
            if (w_apply) begin
                r_left <= r_b0.btn_l;
            end
            r_pkt_valid <= w_apply;
            r_sync_err  <= w_sync;
        end
    end

    // Third byte feeds the y accumulator directly, so it needs no latch
    mouse_axis_acc u_acc_x (
        .clk   (clk),
        .rst   (rst),
        .en    (w_apply && !r_b0.xov),
        .delta ({r_b0.xs, r_b1}),
        .neg   (1'b0),
        .max   (XMAX),
        .init  (XPOS_INIT),
        .pos   (xpos)
    );

    mouse_axis_acc u_acc_y (
        .clk   (clk),
        .rst   (rst),
        .en    (w_apply && !r_b0.yov),
        .delta ({r_b0.ys, rx_data}),
        .neg   (1'b1),
        .max   (YMAX),
        .init  (YPOS_INIT),
        .pos   (ypos)
    );

    assign mouse_left = r_left;
    assign pkt_valid  = r_pkt_valid;
    assign sync_err   = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_mouse_packet_decoder.sv
// ============================================================================
// Module   : tb_mouse_packet_decoder
// Brief    : Scoreboard bench for mouse_packet_decoder with a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mouse_packet_decoder;

    localparam int T    = 100;
    localparam int XMX  = 1023;
    localparam int YMX  = 767;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic        pkt_valid;
    logic        sync_err;

    always #5 clk = ~clk;

    mouse_packet_decoder #(
        .XMAX        (12'd1023),
        .YMAX        (12'd767),
        .XPOS_INIT   (12'd512),
        .YPOS_INIT   (12'd384),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .xpos       (xpos),
        .ypos       (ypos),
        .mouse_left (mouse_left),
        .pkt_valid  (pkt_valid),
        .sync_err   (sync_err)
    );

    typedef struct {
        bit is_pkt;
        int x;
        int y;
        bit left;
    } ev_t;

    ev_t        sb[$];
    ev_t        e_mon;
    int         checks = 0;
    int         errors = 0;
    int         m_x, m_y, m_gap;
    bit         m_left;
    logic [7:0] pend[$];

    function automatic int clampi(int v, int mx);
        return (v < 0) ? 0 : ((v > mx) ? mx : v);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_ev(bit p);
        ev_t e;
        e.is_pkt = p; e.x = m_x; e.y = m_y; e.left = m_left;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_x = 512; m_y = 384; m_left = 0; m_gap = 0;
        pend.delete();
    endtask

    task automatic model_apply();
        logic [7:0] b0, b1, b2;
        int dx, dy;
        b0 = pend[0]; b1 = pend[1]; b2 = pend[2];
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        if (!b0[6]) m_x = clampi(m_x + dx, XMX);
        if (!b0[7]) m_y = clampi(m_y - dy, YMX);
        m_left = b0[0];
        pend.delete();
        push_ev(1'b1);
    endtask

    task automatic send(input logic [7:0] b, input bit err);
        bit s;
        s = 1'b0;
        if (pend.size() != 0 && m_gap == T) begin
            s = 1'b1;
            pend.delete();
        end
        if (err) begin
            s = 1'b1;
            pend.delete();
        end else if (pend.size() == 0 && !b[3]) begin
            s = 1'b1;
        end else begin
            pend.push_back(b);
            if (pend.size() == 3) model_apply();
        end
        if (s) push_ev(1'b0);
        rx_data = b; rx_valid = 1'b1; rx_err = err;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_err = 1'b0;
        m_gap = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (pend.size() != 0 && m_gap == T) begin
                pend.delete();
                push_ev(1'b0);
            end
            @(posedge clk); #1;
            m_gap++;
        end
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(a, 1'b0); send(b, 1'b0); send(c, 1'b0);
    endtask

    task automatic drain();
        idle(4);
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        model_reset();
    endtask

    // Every pulse must match the next expected event, in order
    always @(negedge clk) begin
        if (rst) begin
            if (pkt_valid && sync_err) begin
                checks++; errors++;
                $display("FAIL pulse_overlap pkt_valid=1 sync_err=1 expected at most one");
            end
            if (pkt_valid || sync_err) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse pkt_valid=%0b sync_err=%0b expected none",
                             pkt_valid, sync_err);
                end else begin
                    e_mon = sb.pop_front();
                    if (pkt_valid != e_mon.is_pkt || int'(xpos) != e_mon.x ||
                        int'(ypos) != e_mon.y || mouse_left != e_mon.left) begin
                        errors++;
                        $display("FAIL event actual pkt=%0b x=%0d y=%0d l=%0b expected pkt=%0b x=%0d y=%0d l=%0b",
                                 pkt_valid, xpos, ypos, mouse_left,
                                 e_mon.is_pkt, e_mon.x, e_mon.y, e_mon.left);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit         err;
        int         r, g;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_xpos", int'(xpos), 512);
        chk("reset_ypos", int'(ypos), 384);
        chk("reset_left", int'(mouse_left), 0);
        chk("reset_pkt_valid", int'(pkt_valid), 0);
        chk("reset_sync_err", int'(sync_err), 0);
        #1;

        send3(8'h09, 8'h05, 8'h03);
        drain();
        chk("basic_x", int'(xpos), 517);
        chk("basic_y", int'(ypos), 381);
        chk("basic_left", int'(mouse_left), 1);

        do_reset();
        send3(8'h08, 8'hFF, 8'h00); idle(3); chk("xclamp_1", int'(xpos), 767);
        send3(8'h08, 8'hFF, 8'h00); idle(3); chk("xclamp_2", int'(xpos), 1022);
        send3(8'h08, 8'hFF, 8'h00); idle(3); chk("xclamp_3", int'(xpos), 1023);
        send3(8'h28, 8'h00, 8'h00); idle(3); chk("yclamp_1", int'(ypos), 640);
        send3(8'h28, 8'h00, 8'h00); idle(3); chk("yclamp_2", int'(ypos), 767);
        drain();

        do_reset();
        send3(8'h18, 8'h00, 8'h00); idle(3); chk("xlow_1", int'(xpos), 256);
        send3(8'h18, 8'h00, 8'h00); idle(3); chk("xlow_2", int'(xpos), 0);
        send3(8'h18, 8'h00, 8'h00); idle(3); chk("xlow_3", int'(xpos), 0);
        drain();

        do_reset();
        send(8'h00, 1'b0);
        send3(8'h08, 8'h01, 8'h01);
        drain();
        chk("resync_x", int'(xpos), 513);
        chk("resync_y", int'(ypos), 383);

        do_reset();
        send(8'h08, 1'b0);
        idle(T + 2);
        send3(8'h09, 8'h02, 8'h00);
        drain();
        chk("timeout_x", int'(xpos), 514);
        chk("timeout_left", int'(mouse_left), 1);
        send3(8'hC9, 8'h7F, 8'h7F);
        drain();
        chk("ovf_x", int'(xpos), 514);
        chk("ovf_y", int'(ypos), 384);

        // Gap just under the limit keeps the packet; gap at the limit restarts it
        send(8'h08, 1'b0); idle(T - 1); send(8'h03, 1'b0); send(8'h00, 1'b0);
        drain();
        chk("gap_under_x", int'(xpos), 517);
        send(8'h08, 1'b0); idle(T); send3(8'h08, 8'h04, 8'h00);
        drain();
        chk("gap_at_x", int'(xpos), 521);

        send(8'h08, 1'b0); send(8'h05, 1'b1);
        send3(8'h08, 8'h01, 8'h00);
        drain();
        chk("rxerr_x", int'(xpos), 522);

        send(8'h09, 1'b0); send(8'h40, 1'b0);
        do_reset();
        send3(8'h09, 8'h05, 8'h03);
        drain();
        chk("midreset_x", int'(xpos), 517);
        chk("midreset_y", int'(ypos), 381);

        do_reset();
        for (int i = 0; i < 700; i++) begin
            b = 8'($urandom);
            if (pend.size() == 0 && ($urandom % 10) != 0) b[3] = 1'b1;
            err = (($urandom % 50) == 0);
            r = $urandom % 40;
            case (r)
                0:       g = T - 1;
                1:       g = T;
                2:       g = T + 3;
                default: g = $urandom % 3;
            endcase
            idle(g);
            send(b, err);
        end
        idle(T + 5);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
